// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
// Frame layout puts dp/seg in the far 595 and sel in the near one.
package hc595_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } state_e;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic       dp,
        input logic [6:0] seg,
        input logic [7:0] sel
    );
        return {dp, seg, sel};
    endfunction

endpackage

// File: rtl/hc595_if.sv
// Scanner-side inputs and 595-side outputs of the chain driver.
// The driver takes the slave view; the scan stage/board takes master.
interface hc595_if;

    logic [7:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       en;
    logic       ds;
    logic       shcp;
    logic       stcp;
    logic       oe_n;
    logic       busy;

    modport master (
        output sel, seg, dp, en,
        input  ds, shcp, stcp, oe_n, busy
    );

    modport slave (
        input  sel, seg, dp, en,
        output ds, shcp, stcp, oe_n, busy
    );

endinterface

// File: rtl/hc595_tick_gen.sv
// Shift-tick divider: counts 0..CLK_DIV-1 while running.
// Held at zero by a synchronous clear while the driver is idle.
module hc595_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/hc595_driver.sv
// Serialises {dp, seg, sel} into two chained 74HC595s on change.
// All pin outputs come straight from flops.
module hc595_driver #(
    parameter int CLK_DIV = 2,
    parameter int FRAME_W = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    hc595_if.slave  bus
);

    import hc595_pkg::*;

    localparam int BW = $clog2(FRAME_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

    state_e             state_q;
    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] last_q;
    logic               valid_q;
    logic [BW-1:0]      bit_q;
    logic               ds_q;
    logic               shcp_q;
    logic               stcp_q;
    logic               oe_n_q;
    logic               busy_q;
    logic               tick;
    logic [FRAME_W-1:0] frame;

    assign frame = pack_frame(bus.dp, bus.seg, bus.sel);

    hc595_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            bit_q   <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            oe_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            oe_n_q <= ~bus.en;
            unique case (state_q)
                IDLE: begin
                    shcp_q <= 1'b0;
                    stcp_q <= 1'b0;
                    if (!valid_q || frame != last_q) begin
                        sr_q    <= frame;
                        last_q  <= frame;
                        valid_q <= 1'b1;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        ds_q    <= frame[FRAME_W-1];
                        state_q <= SHIFT_LO;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        shcp_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        shcp_q <= 1'b0;
                        sr_q   <= sr_q << 1;
                        ds_q   <= sr_q[FRAME_W-2];
                        bit_q  <= bit_q + 1'b1;
                        // Latch strobe rises as the last bit's shcp falls
                        if (bit_q == LAST_BIT) begin
                            stcp_q  <= 1'b1;
                            state_q <= LATCH_HI;
                        end else begin
                            state_q <= SHIFT_LO;
                        end
                    end
                end
                LATCH_HI: begin
                    if (tick) begin
                        stcp_q  <= 1'b0;
                        state_q <= LATCH_LO;
                    end
                end
                LATCH_LO: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ds   = ds_q;
    assign bus.shcp = shcp_q;
    assign bus.stcp = stcp_q;
    assign bus.oe_n = oe_n_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: CLK_DIV=2 and CLK_DIV=1 instances.
// Frames are decoded off the pins and compared to a reference.
module tb_hc595_driver;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    bit   use_b;

    always #5 clk = ~clk;

    hc595_if a_if ();
    hc595_if b_if ();

    hc595_driver #(.CLK_DIV(2), .FRAME_W(16)) u_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (a_if.slave)
    );

    hc595_driver #(.CLK_DIV(1), .FRAME_W(16)) u_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (b_if.slave)
    );

    logic m_ds, m_shcp, m_stcp, m_busy;
    assign m_ds   = use_b ? b_if.ds   : a_if.ds;
    assign m_shcp = use_b ? b_if.shcp : a_if.shcp;
    assign m_stcp = use_b ? b_if.stcp : a_if.stcp;
    assign m_busy = use_b ? b_if.busy : a_if.busy;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: the wire order of bits as seen on ds at each shcp rise
    function automatic logic [15:0] ref_frame(
        logic dp, logic [6:0] seg, logic [7:0] sel
    );
        logic [15:0] f;
        f[15]    = dp;
        f[14:8]  = seg;
        f[7:0]   = sel;
        return f;
    endfunction

    typedef struct {
        logic [15:0] bits;
        int nrise;
        int first_rise;
        int stcp_off;
        int stcp_w;
        int nstcp;
        int busy_len;
        int bad_gap;
        int wait_n;
        bit to;
    } cap_t;

    task automatic capture(input int div, output cap_t r);
        int c;
        int last;
        logic ps, pt;
        r = '{default: 0};
        c = 0;
        while (!m_busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        r.wait_n = c;
        if (!m_busy) begin
            r.to = 1;
            return;
        end
        c = 1; ps = 0; pt = 0; last = -1;
        while (m_busy && c < 400) begin
            if (m_shcp && !ps) begin
                r.bits = {r.bits[14:0], m_ds};
                r.nrise++;
                if (last < 0) r.first_rise = c;
                else if (c - last != 2 * div) r.bad_gap++;
                last = c;
            end
            if (m_stcp && !pt) begin
                r.nstcp++;
                r.stcp_off = c;
            end
            if (m_stcp) r.stcp_w++;
            ps = m_shcp;
            pt = m_stcp;
            @(negedge clk);
            c++;
        end
        r.busy_len = c - 1;
        if (m_busy) r.to = 1;
    endtask

    task automatic check_frame(string tag, cap_t r, int div, logic [15:0] exp);
        check({tag, " timeout"}, r.to, 0);
        check({tag, " bits"}, r.bits, exp);
        check({tag, " rises"}, r.nrise, 16);
        check({tag, " stcp pulses"}, r.nstcp, 1);
        check({tag, " first rise"}, r.first_rise, div + 1);
        check({tag, " rise spacing"}, r.bad_gap, 0);
        check({tag, " stcp offset"}, r.stcp_off, 32 * div + 1);
        check({tag, " stcp width"}, r.stcp_w, div);
        check({tag, " busy len"}, r.busy_len, 34 * div);
    endtask

    initial begin
        cap_t r, r2;
        int act, k;
        logic [15:0] v, prev;

        use_b = 0;
        rst_a_n = 0;
        rst_b_n = 0;
        a_if.sel = 8'h01; a_if.seg = 7'h40; a_if.dp = 1'b1; a_if.en = 1'b1;
        b_if.sel = 8'h00; b_if.seg = 7'h00; b_if.dp = 1'b0; b_if.en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outs", {a_if.ds, a_if.shcp, a_if.stcp, a_if.oe_n, a_if.busy},
              5'b00010);

        rst_a_n = 1;
        capture(2, r);
        check_frame("first", r, 2, ref_frame(1'b1, 7'h40, 8'h01));
        check("first bits lit", r.bits, 16'hC001);

        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (a_if.shcp || a_if.stcp || a_if.busy) act++;
        end
        check("idle activity", act, 0);

        a_if.seg = 7'h79;
        fork
            capture(2, r);
            begin
                k = 0;
                while (!a_if.busy && k < 400) begin @(negedge clk); k++; end
                repeat (9) @(negedge clk);
                a_if.sel = 8'h02;
                repeat (20) @(negedge clk);
                a_if.sel = 8'h04;
            end
        join
        check_frame("snap", r, 2, ref_frame(1'b1, 7'h79, 8'h01));
        capture(2, r2);
        check_frame("collapse", r2, 2, ref_frame(1'b1, 7'h79, 8'h04));
        check("idle gap", r2.wait_n, 1);
        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_if.busy) act++;
        end
        check("no extra frame", act, 0);

        a_if.en = 1'b0;
        #1 check("oe_n delay", a_if.oe_n, 1'b0);
        @(negedge clk);
        check("oe_n off", a_if.oe_n, 1'b1);
        repeat (10) @(negedge clk);
        a_if.en = 1'b1;
        #1 check("oe_n hold", a_if.oe_n, 1'b1);
        @(negedge clk);
        check("oe_n on", a_if.oe_n, 1'b0);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_if.busy) act++;
        end
        check("en no frame", act, 0);

        a_if.dp = 1'b0;
        k = 0; act = 0;
        begin
            int rises;
            logic ps;
            rises = 0; ps = 0;
            while (rises < 8 && k < 400) begin
                @(negedge clk);
                k++;
                if (a_if.shcp && !ps) rises++;
                if (a_if.stcp) act++;
                ps = a_if.shcp;
            end
            check("abort reach", rises, 8);
        end
        rst_a_n = 0;
        #1 check("abort outs",
                 {a_if.ds, a_if.shcp, a_if.stcp, a_if.oe_n, a_if.busy}, 5'b00010);
        repeat (3) begin
            @(negedge clk);
            if (a_if.stcp) act++;
        end
        check("abort no stcp", act, 0);
        rst_a_n = 1;
        capture(2, r);
        check_frame("restart", r, 2, ref_frame(1'b0, 7'h79, 8'h04));

        use_b = 1;
        prev = 16'($urandom);
        {b_if.dp, b_if.seg, b_if.sel} = prev;
        @(negedge clk);
        rst_b_n = 1;
        capture(1, r);
        check_frame("div1", r, 1, ref_frame(prev[15], prev[14:8], prev[7:0]));
        for (int i = 0; i < 200; i++) begin
            v = 16'($urandom);
            if (v == prev) v = v ^ 16'h0001;
            b_if.dp  = v[15];
            b_if.seg = v[14:8];
            b_if.sel = v[7:0];
            capture(1, r);
            check("rand bits", r.to ? 32'hDEAD : {16'h0, r.bits},
                  {16'h0, ref_frame(v[15], v[14:8], v[7:0])});
            prev = v;
        end
        check("rand last stcp", r.nstcp, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
